// File: rtl/blake2b_pkg.sv
// BLAKE2b constants, message schedule and shared types.
package blake2b_pkg;

   typedef logic [63:0]       word_t;
   typedef logic [7:0][63:0]  hash_t;
   typedef logic [15:0][63:0] blk_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COMPRESS,
      ST_FINISH,
      ST_HOLD
   } state_t;

   // IV[0] sits in the low word so that IV ^ parameter-block lines up bytewise.
   localparam hash_t IV = {
      64'h5be0cd19137e2179, 64'h1f83d9abfb41bd6b,
      64'h9b05688c2b3e6c1f, 64'h510e527fade682d1,
      64'ha54ff53a5f1d36f1, 64'h3c6ef372fe94f82b,
      64'hbb67ae8584caa73b, 64'h6a09e667f3bcc908
   };

   // One row per round, nibble j (LSB first) is sigma[r][j].
   localparam logic [63:0] SIGMA [10] = '{
      64'hfedcba9876543210,
      64'h357b20c16df984ae,
      64'h491763eadf250c8b,
      64'h8f04a562ebcd1397,
      64'hd386cb1efa427509,
      64'h91ef57d438b0a6c2,
      64'hb8293670a4def15c,
      64'ha2684f05931ce7bd,
      64'h5a417d2c803b9ef6,
      64'h0dc3e9bf5167482a
   };

   localparam int R1 = 32;
   localparam int R2 = 24;
   localparam int R3 = 16;
   localparam int R4 = 63;

   function automatic word_t rotr(input word_t x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic logic [3:0] sigma_at(input logic [3:0] r, input logic [3:0] j);
      logic [63:0] row;
      row = SIGMA[r];
      return row[{j, 2'b00} +: 4];
   endfunction

   // A block is the last one when no more than 128 bytes remain from its start.
   function automatic logic is_final(input logic [7:0] len, input logic idx);
      logic [8:0] rem;
      rem = {1'b0, len} - {1'b0, idx, 7'b0};
      return rem <= 9'd128;
   endfunction

endpackage

// File: rtl/blake2b_g.sv
// Combinational BLAKE2b G mixing function on four state words.
module blake2b_g
   import blake2b_pkg::*;
(
   input  logic [63:0] a_i,
   input  logic [63:0] b_i,
   input  logic [63:0] c_i,
   input  logic [63:0] d_i,
   input  logic [63:0] m0_i,
   input  logic [63:0] m1_i,
   output logic [63:0] a_o,
   output logic [63:0] b_o,
   output logic [63:0] c_o,
   output logic [63:0] d_o
);

   word_t a1, b1, c1, d1, a2, b2, c2, d2;

   // Two half-mixes, each add/xor/rotate chain fed by one message word.
   always_comb begin
      a1 = a_i + b_i + m0_i;
      d1 = rotr(d_i ^ a1, R1);
      c1 = c_i + d1;
      b1 = rotr(b_i ^ c1, R2);
      a2 = a1 + b1 + m1_i;
      d2 = rotr(d1 ^ a2, R3);
      c2 = c1 + d2;
      b2 = rotr(b1 ^ c2, R4);
   end

   assign a_o = a2;
   assign b_o = b2;
   assign c_o = c2;
   assign d_o = d2;

endmodule

// File: rtl/blake2b_iter_hash.sv
// Iterative BLAKE2b engine: one 128-byte block per beat, 64-byte digest out.
// A compression takes one init cycle plus a half-round (4 G in parallel) per cycle.
module blake2b_iter_hash
   import blake2b_pkg::*;
#(
   parameter int NUM_ROUNDS = 12
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [511:0]  i_parameters,
   input  logic [7:0]    i_byte_len,
   input  logic [1023:0] i_block_dat,
   input  logic          i_block_val,
   output logic          i_block_rdy,
   input  logic          i_block_sop,
   input  logic          i_block_eop,
   input  logic [6:0]    i_block_mod,
   input  logic          i_block_err,
   input  logic [7:0]    i_block_ctl,
   output logic [511:0]  o_hash_dat,
   output logic          o_hash_val,
   input  logic          o_hash_rdy,
   output logic          o_hash_sop,
   output logic          o_hash_eop,
   output logic [5:0]    o_hash_mod,
   output logic          o_hash_err,
   output logic [7:0]    o_hash_ctl
);

   localparam logic [4:0] LAST_CYC = 5'(2 * NUM_ROUNDS);

   state_t     state_q;
   logic       rdy_q, mid_q, final_q, blk_idx_q;
   logic [4:0] cyc_q;
   logic [7:0] len_q;
   hash_t      h_q;
   blk_t       v_q, m_q;
   logic       o_val_q, o_sop_q, o_eop_q;
   hash_t      o_dat_q;

   logic          acc;
   logic [7:0]    len_cur;
   logic [8:0]    rem_len;
   logic [1023:0] m_ld;
   logic [63:0]   t_lo;
   blk_t          v_init, v_rnd;
   hash_t         h_fin;
   logic [4:0]    step;
   logic          diag;
   logic [3:0]    rnd, srnd;
   logic [3:0][63:0] ga, gb, gc, gd, gm0, gm1;
   logic [3:0][63:0] ga_o, gb_o, gc_o, gd_o;

   logic unused_in;
   assign unused_in = ^{i_block_eop, i_block_mod, i_block_err, i_block_ctl};

   // A sop starts a message only when no second block is pending.
   assign acc     = rdy_q && i_block_val && (mid_q || i_block_sop);
   assign len_cur = mid_q ? len_q : i_byte_len;

   // Zero every message byte past the end of the message.
   always_comb begin
      rem_len = mid_q ? ({1'b0, len_q} - 9'd128) : {1'b0, i_byte_len};
      m_ld    = '0;
      for (int k = 0; k < 128; k++)
         m_ld[k*8 +: 8] = (9'(k) < rem_len) ? i_block_dat[k*8 +: 8] : 8'h00;
   end

   // Working vector seed: counter into v12, final flag inverts v14.
   always_comb begin
      t_lo   = final_q ? 64'(len_q) : (64'({1'b0, blk_idx_q} + 2'd1) << 7);
      v_init = {IV[7], IV[6] ^ {64{final_q}}, IV[5], IV[4] ^ t_lo, IV[3:0], h_q};
      h_fin  = h_q ^ v_q[7:0] ^ v_q[15:8];
   end

   // Gather G operands: even steps use columns, odd steps diagonals.
   always_comb begin
      step = cyc_q - 5'd1;
      diag = step[0];
      rnd  = step[4:1];
      srnd = (rnd >= 4'd10) ? rnd - 4'd10 : rnd;
      ga = '0; gb = '0; gc = '0; gd = '0; gm0 = '0; gm1 = '0;
      for (int i = 0; i < 4; i++) begin
         ga[i]  = v_q[4'(i)];
         gb[i]  = diag ? v_q[4'(4 + ((i + 1) % 4))]  : v_q[4'(4 + i)];
         gc[i]  = diag ? v_q[4'(8 + ((i + 2) % 4))]  : v_q[4'(8 + i)];
         gd[i]  = diag ? v_q[4'(12 + ((i + 3) % 4))] : v_q[4'(12 + i)];
         gm0[i] = m_q[sigma_at(srnd, {diag, 2'(i), 1'b0})];
         gm1[i] = m_q[sigma_at(srnd, {diag, 2'(i), 1'b1})];
      end
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_mix
      blake2b_g u_g (
         .a_i (ga[gi]),  .b_i (gb[gi]),  .c_i (gc[gi]),  .d_i (gd[gi]),
         .m0_i(gm0[gi]), .m1_i(gm1[gi]),
         .a_o (ga_o[gi]), .b_o (gb_o[gi]), .c_o (gc_o[gi]), .d_o (gd_o[gi])
      );
   end

   // Scatter G results back to the same positions they were read from.
   always_comb begin
      v_rnd = v_q;
      for (int i = 0; i < 4; i++) begin
         v_rnd[4'(i)] = ga_o[i];
         if (diag) begin
            v_rnd[4'(4 + ((i + 1) % 4))]  = gb_o[i];
            v_rnd[4'(8 + ((i + 2) % 4))]  = gc_o[i];
            v_rnd[4'(12 + ((i + 3) % 4))] = gd_o[i];
         end else begin
            v_rnd[4'(4 + i)]  = gb_o[i];
            v_rnd[4'(8 + i)]  = gc_o[i];
            v_rnd[4'(12 + i)] = gd_o[i];
         end
      end
   end

   // Datapath registers: chaining value, message and working vector.
   always_ff @(posedge i_clk) begin
      if (acc) begin
         m_q <= m_ld;
         if (!mid_q) begin
            h_q   <= IV ^ i_parameters;
            len_q <= i_byte_len;
         end
      end
      if (state_q == ST_COMPRESS)
         v_q <= (cyc_q == 5'd0) ? v_init : v_rnd;
      if (state_q == ST_FINISH)
         h_q <= h_fin;
   end

   // Control FSM with registered handshake and digest outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         rdy_q     <= 1'b0;
         mid_q     <= 1'b0;
         final_q   <= 1'b0;
         blk_idx_q <= 1'b0;
         cyc_q     <= '0;
         o_val_q   <= 1'b0;
         o_sop_q   <= 1'b0;
         o_eop_q   <= 1'b0;
         o_dat_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               rdy_q <= 1'b1;
               if (acc) begin
                  rdy_q     <= 1'b0;
                  state_q   <= ST_COMPRESS;
                  cyc_q     <= '0;
                  blk_idx_q <= mid_q;
                  final_q   <= is_final(len_cur, mid_q);
               end
            end
            ST_COMPRESS: begin
               cyc_q <= cyc_q + 5'd1;
               if (cyc_q == LAST_CYC)
                  state_q <= ST_FINISH;
            end
            ST_FINISH: begin
               if (final_q) begin
                  o_dat_q <= h_fin;
                  o_val_q <= 1'b1;
                  o_sop_q <= 1'b1;
                  o_eop_q <= 1'b1;
                  mid_q   <= 1'b0;
                  state_q <= ST_HOLD;
               end else begin
                  mid_q   <= 1'b1;
                  rdy_q   <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            ST_HOLD: begin
               if (o_hash_rdy) begin
                  o_val_q <= 1'b0;
                  o_sop_q <= 1'b0;
                  o_eop_q <= 1'b0;
                  o_dat_q <= '0;
                  rdy_q   <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign i_block_rdy = rdy_q;
   assign o_hash_dat  = o_dat_q;
   assign o_hash_val  = o_val_q;
   assign o_hash_sop  = o_sop_q;
   assign o_hash_eop  = o_eop_q;
   assign o_hash_mod  = '0;
   assign o_hash_err  = 1'b0;
   assign o_hash_ctl  = '0;

endmodule

// File: tb/tb_blake2b_iter_hash.sv
// Directed-vector bench for blake2b_iter_hash using published BLAKE2b-512 digests.
module tb_blake2b_iter_hash;

   localparam logic [511:0] EXP_ABC =
      512'h239900d4ed8623b95a92f1dba88ad31895cc3345ded552c22d79ab2a39c5877dd1a2ffdb6fbb124bb7c45a68142f214ce9f6129fb697276a0d4d1c983fa580ba;
   localparam logic [511:0] EXP_FULL =
      512'hd2a56bb7bb1ff1fffcf2f151522455e32969ddfeb409b105f45299b8cbd68eb370fd6d45d63981d23cd2686dfd9a76f5b1d134be076f7d08ecc457522042e34a;
   localparam logic [511:0] EXP_TWO =
      512'h2012a869a3b89a69ffc954f6855c7f61a61190553dc487171ec3fe944d04c83cd4c842fff5a8258d5e14b05b7b6f30e8ddcb754d719137ec42fb5cdb562f8c89;
   localparam logic [511:0] EXP_EMPTY =
      512'hcee29bfe1a706fd555b748145b683a904bb04e93446489135358eeaf31105ed219541ff717e2868a614758e140472f9172d2522585fdc6c603590142f7026a78;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic [511:0]  i_parameters = '0;
   logic [7:0]    i_byte_len = '0;
   logic [1023:0] i_block_dat = '0;
   logic          i_block_val = 1'b0;
   logic          i_block_rdy;
   logic          i_block_sop = 1'b0;
   logic          i_block_eop = 1'b0;
   logic [6:0]    i_block_mod = '0;
   logic          i_block_err = 1'b0;
   logic [7:0]    i_block_ctl = '0;
   logic [511:0]  o_hash_dat;
   logic          o_hash_val;
   logic          o_hash_rdy = 1'b0;
   logic          o_hash_sop;
   logic          o_hash_eop;
   logic [5:0]    o_hash_mod;
   logic          o_hash_err;
   logic [7:0]    o_hash_ctl;

   int total = 0;
   int bad   = 0;

   blake2b_iter_hash #(.NUM_ROUNDS(12)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_parameters(i_parameters), .i_byte_len(i_byte_len),
      .i_block_dat(i_block_dat), .i_block_val(i_block_val), .i_block_rdy(i_block_rdy),
      .i_block_sop(i_block_sop), .i_block_eop(i_block_eop), .i_block_mod(i_block_mod),
      .i_block_err(i_block_err), .i_block_ctl(i_block_ctl),
      .o_hash_dat(o_hash_dat), .o_hash_val(o_hash_val), .o_hash_rdy(o_hash_rdy),
      .o_hash_sop(o_hash_sop), .o_hash_eop(o_hash_eop), .o_hash_mod(o_hash_mod),
      .o_hash_err(o_hash_err), .o_hash_ctl(o_hash_ctl)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic logic [1023:0] rnd1024();
      logic [1023:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Inputs change on the falling edge; the handshake lands on the next rising edge.
   task automatic send_beat(input logic [1023:0] d, input logic s, input logic e);
      int n;
      n = 0;
      i_block_dat = d; i_block_sop = s; i_block_eop = e; i_block_val = 1'b1;
      while (!i_block_rdy && n < 300) begin
         @(negedge i_clk);
         n++;
      end
      if (!i_block_rdy) chk("timeout_in_rdy", i_block_rdy, 1);
      @(negedge i_clk);
      i_block_val = 1'b0; i_block_sop = 1'b0; i_block_eop = 1'b0;
   endtask

   task automatic wait_val(output bit ok);
      int n;
      n = 0;
      while (!o_hash_val && n < 300) begin
         @(negedge i_clk);
         n++;
      end
      ok = o_hash_val;
      if (!ok) chk("timeout_out_val", o_hash_val, 1);
   endtask

   task automatic take_hash(input string tag, input logic [511:0] exp);
      bit ok;
      wait_val(ok);
      if (ok) begin
         chk({tag, "_dat"}, o_hash_dat, exp);
         chk({tag, "_ctl"}, {o_hash_sop, o_hash_eop, o_hash_mod, o_hash_err, o_hash_ctl},
             {1'b1, 1'b1, 6'd0, 1'b0, 8'd0});
         o_hash_rdy = 1'b1;
         @(negedge i_clk);
         o_hash_rdy = 1'b0;
         chk({tag, "_val_drop"}, o_hash_val, 0);
      end
   endtask

   task automatic run_one(input string tag, input logic [7:0] len, input logic [1023:0] b,
                          input logic [511:0] exp);
      i_byte_len = len;
      send_beat(b, 1'b1, 1'b1);
      take_hash(tag, exp);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1);
   end

   initial begin
      logic [511:0]  prm;
      logic [1023:0] b, lit128;
      logic [1119:0] lit140;
      bit            ok;
      int            hs, vh;

      prm = '0;
      prm[63:0] = {32'd0, 8'd1, 8'd1, 8'd0, 8'd64};
      lit128 = "monek14SFMpNgHz12zMfplMfcHkx6JhKhSWTNwzGiq8UiPa4n4Ehq363oHG92GPDVpvQut4ui5e6XxieeKTn1THLWiMZ0iaOFndxcT6FGPgmHXQ5zJU96X71zfWbvUQs";
      lit140 = "YbEAEzgJ1tgC3t6vDaJFqlWp1PaL482f7iZZzRj3xXpY2PPupwdTKAaBzB6KuN6j0alaoaFQfNboDbkNv5KDs5d7zN9JssrtOjGJdrVLfvb7uAdnVYoIgIv2zbXUQIPpwWdzEzj1CzX5";

      // reset state
      repeat (3) @(negedge i_clk);
      chk("rst_in_rdy", i_block_rdy, 0);
      chk("rst_out_val", o_hash_val, 0);
      chk("rst_out_dat", o_hash_dat, 0);
      chk("rst_out_flags", {o_hash_sop, o_hash_eop}, 0);
      i_rst = 1'b0;
      @(negedge i_clk);
      chk("in_rdy_after_rst", i_block_rdy, 1);
      i_parameters = prm;

      // "abc" with junk above byte 2 that must be masked off
      b = rnd1024();
      b[23:0] = 24'h636261;
      run_one("abc", 8'd3, b, EXP_ABC);

      // exactly one full block
      run_one("full128", 8'd128, lit128, EXP_FULL);

      // two blocks; second beat carries sop (must not restart) and junk tail
      i_byte_len = 8'd140;
      send_beat(lit140[1023:0], 1'b1, 1'b0);
      i_byte_len   = 8'hff;
      i_parameters = '1;
      b = rnd1024();
      b[95:0] = lit140[1119:1024];
      send_beat(b, 1'b1, 1'b1);
      take_hash("two140", EXP_TWO);
      i_parameters = prm;

      // empty message: random data must be fully masked
      run_one("empty", 8'd0, rnd1024(), EXP_EMPTY);

      // output backpressure
      b = rnd1024();
      b[23:0] = 24'h636261;
      i_byte_len = 8'd3;
      send_beat(b, 1'b1, 1'b1);
      chk("busy_in_rdy", i_block_rdy, 0);
      wait_val(ok);
      if (ok) begin
         for (int c = 0; c < 20; c++) begin
            chk("bp_dat", o_hash_dat, EXP_ABC);
            chk("bp_val", o_hash_val, 1);
            chk("bp_in_rdy", i_block_rdy, 0);
            @(negedge i_clk);
         end
         o_hash_rdy = 1'b1;
         hs = 0;
         for (int c = 0; c < 8; c++) begin
            if (o_hash_val) hs++;
            @(negedge i_clk);
         end
         o_hash_rdy = 1'b0;
         chk("bp_handshakes", hs, 1);
      end

      // reset in the middle of a compression
      b = rnd1024();
      b[23:0] = 24'h636261;
      i_byte_len = 8'd3;
      send_beat(b, 1'b1, 1'b1);
      repeat (9) @(negedge i_clk);
      i_rst = 1'b1;
      repeat (2) @(negedge i_clk);
      chk("midrst_in_rdy", i_block_rdy, 0);
      chk("midrst_out_val", o_hash_val, 0);
      i_rst = 1'b0;
      o_hash_rdy = 1'b1;
      vh = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge i_clk);
         if (o_hash_val) vh++;
      end
      o_hash_rdy = 1'b0;
      chk("midrst_no_digest", vh, 0);
      b = rnd1024();
      b[23:0] = 24'h636261;
      run_one("abc_after_rst", 8'd3, b, EXP_ABC);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
